// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline boundary: NUM_PORTS GPR write lanes plus a HI/LO lane behind a
// valid/ready handshake with a two-entry skid buffer, flush and bubble suppression.
//
// state | meaning
// EMPTY | no entry held; out_valid=0
// ONE   | main entry presented to WB, skid empty
// FULL  | main presented, skid holds the next entry; in_ready=0
module mem_wb_pipe #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NUM_PORTS = 1,
    parameter logic [AW-1:0] NOP_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_PORTS*AW-1:0] in_wd,
    input  logic [NUM_PORTS-1:0]    in_wreg,
    input  logic [NUM_PORTS*DW-1:0] in_wdata,
    input  logic                    in_whilo,
    input  logic [DW-1:0]           in_hi,
    input  logic [DW-1:0]           in_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_PORTS*AW-1:0] out_wd,
    output logic [NUM_PORTS-1:0]    out_wreg,
    output logic [NUM_PORTS*DW-1:0] out_wdata,
    output logic                    out_whilo,
    output logic [DW-1:0]           out_hi,
    output logic [DW-1:0]           out_lo
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    logic                    main_v, skid_v, in_ready_r;
    logic [NUM_PORTS*AW-1:0] main_wd, skid_wd;
    logic [NUM_PORTS-1:0]    main_wreg, skid_wreg;
    logic [NUM_PORTS*DW-1:0] main_wdata, skid_wdata;
    logic                    main_whilo, skid_whilo;
    logic [DW-1:0]           main_hi, main_lo, skid_hi, skid_lo;

    logic                    in_fire, out_fire;
    logic [NUM_PORTS*AW-1:0] in_wd_m;
    state_t                  st;

    assign in_fire  = in_valid & in_ready_r;
    assign out_fire = main_v & out_ready;
    assign st       = state_t'({main_v, skid_v});

    // Lanes without a write carry NOP_ADDR so WB never sees a stale destination.
    always_comb begin
        in_wd_m = in_wd;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!in_wreg[i]) in_wd_m[i*AW +: AW] = NOP_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v     <= 1'b0;
            skid_v     <= 1'b0;
            in_ready_r <= 1'b1;
            main_wd    <= {NUM_PORTS{NOP_ADDR}};
            main_wreg  <= '0;
            main_wdata <= '0;
            main_whilo <= 1'b0;
            main_hi    <= '0;
            main_lo    <= '0;
            skid_wd    <= {NUM_PORTS{NOP_ADDR}};
            skid_wreg  <= '0;
            skid_wdata <= '0;
            skid_whilo <= 1'b0;
            skid_hi    <= '0;
            skid_lo    <= '0;
        end else if (flush) begin
            main_v     <= 1'b0;
            skid_v     <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            case (st)
                EMPTY: begin
                    in_ready_r <= 1'b1;
                    if (in_fire) begin
                        main_v     <= 1'b1;
                        main_wd    <= in_wd_m;
                        main_wreg  <= in_wreg;
                        main_wdata <= in_wdata;
                        main_whilo <= in_whilo;
                        main_hi    <= in_hi;
                        main_lo    <= in_lo;
                    end
                end
                ONE: begin
                    in_ready_r <= !(in_fire && !out_fire);
                    if (in_fire && out_fire) begin
                        main_wd    <= in_wd_m;
                        main_wreg  <= in_wreg;
                        main_wdata <= in_wdata;
                        main_whilo <= in_whilo;
                        main_hi    <= in_hi;
                        main_lo    <= in_lo;
                    end else if (in_fire) begin
                        skid_v     <= 1'b1;
                        skid_wd    <= in_wd_m;
                        skid_wreg  <= in_wreg;
                        skid_wdata <= in_wdata;
                        skid_whilo <= in_whilo;
                        skid_hi    <= in_hi;
                        skid_lo    <= in_lo;
                    end else if (out_fire) begin
                        main_v <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        skid_v     <= 1'b0;
                        in_ready_r <= 1'b1;
                        main_wd    <= skid_wd;
                        main_wreg  <= skid_wreg;
                        main_wdata <= skid_wdata;
                        main_whilo <= skid_whilo;
                        main_hi    <= skid_hi;
                        main_lo    <= skid_lo;
                    end
                end
                default: begin
                    main_v     <= 1'b0;
                    skid_v     <= 1'b0;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Enables are masked by valid so a handshake-less WB never commits a bubble.
    assign in_ready  = in_ready_r;
    assign out_valid = main_v;
    assign out_wd    = main_wd;
    assign out_wreg  = main_wreg & {NUM_PORTS{main_v}};
    assign out_wdata = main_wdata;
    assign out_whilo = main_whilo & main_v;
    assign out_hi    = main_hi;
    assign out_lo    = main_lo;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe with two lanes: reset, streaming, backpressure,
// flush in FULL, reset from FULL, lane masking and HI/LO.
module tb_mem_wb_pipe;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [NP*AW-1:0]  in_wd, out_wd;
    logic [NP-1:0]     in_wreg, out_wreg;
    logic [NP*DW-1:0]  in_wdata, out_wdata;
    logic              in_whilo, out_whilo;
    logic [DW-1:0]     in_hi, in_lo, out_hi, out_lo;

    int n_cmp = 0;
    int n_bad = 0;

    mem_wb_pipe #(.DW(DW), .AW(AW), .NUM_PORTS(NP), .NOP_ADDR(5'd0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .in_whilo(in_whilo), .in_hi(in_hi), .in_lo(in_lo),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
        .out_whilo(out_whilo), .out_hi(out_hi), .out_lo(out_lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single-lane payload on lane 0 with write enabled.
    task automatic drive0(input logic [AW-1:0] wd, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_wreg  = 2'b01;
        in_wd    = {5'd0, wd};
        in_wdata = {32'h0, d};
        in_whilo = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_wd = '0; in_wreg = '0; in_wdata = '0; in_whilo = 1'b0; in_hi = '0; in_lo = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_wd", out_wd, 0);
        chk("rst_out_wdata", out_wdata, 0);
        chk("rst_out_hi", out_hi, 0);

        // Streaming
        out_ready = 1'b1;
        drive0(5'd3, 32'h11); tick();
        chk("s1_valid", out_valid, 1); chk("s1_wd", out_wd, 10'd3);
        chk("s1_wdata", out_wdata, 64'h11); chk("s1_wreg", out_wreg, 2'b01);
        drive0(5'd4, 32'h22); tick();
        chk("s2_wd", out_wd, 10'd4); chk("s2_wdata", out_wdata, 64'h22);
        chk("s2_in_ready", in_ready, 1);
        drive0(5'd5, 32'h33); tick();
        chk("s3_wd", out_wd, 10'd5); chk("s3_wdata", out_wdata, 64'h33);
        chk("s3_wreg", out_wreg, 2'b01);
        in_valid = 1'b0; tick();
        chk("s4_valid", out_valid, 0); chk("s4_wreg", out_wreg, 0);
        chk("s4_hold_wdata", out_wdata, 64'h33);

        // Backpressure
        out_ready = 1'b0;
        drive0(5'd1, 32'hA); tick();
        chk("bp_a_in_ready", in_ready, 1); chk("bp_a_out", out_wdata, 64'hA);
        drive0(5'd2, 32'hB); tick();
        chk("bp_full_in_ready", in_ready, 0); chk("bp_full_out", out_wdata, 64'hA);
        drive0(5'd6, 32'hC); tick();
        chk("bp_ignored_out", out_wdata, 64'hA); chk("bp_ignored_rdy", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("bp_b_out", out_wdata, 64'hB); chk("bp_b_wd", out_wd, 10'd2);
        chk("bp_b_in_ready", in_ready, 1); chk("bp_b_valid", out_valid, 1);
        tick();
        chk("bp_drain_valid", out_valid, 0);

        // Flush in FULL
        out_ready = 1'b0;
        drive0(5'd1, 32'hA); tick();
        drive0(5'd2, 32'hB); tick();
        chk("fl_full", in_ready, 0);
        drive0(5'd6, 32'hC); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", out_valid, 0); chk("fl_in_ready", in_ready, 1);
        chk("fl_wreg", out_wreg, 0);
        out_ready = 1'b1; tick();
        chk("fl_no_c", out_valid, 0);

        // Reset from FULL
        out_ready = 1'b0;
        drive0(5'd1, 32'hA); tick();
        drive0(5'd2, 32'hB); tick();
        in_valid = 1'b0; rst = 1'b1; tick();
        chk("rf_valid", out_valid, 0); chk("rf_in_ready", in_ready, 1);
        chk("rf_wreg", out_wreg, 0); chk("rf_wd", out_wd, 0);
        chk("rf_wdata", out_wdata, 0);
        tick(); rst = 1'b0;
        out_ready = 1'b1;
        drive0(5'd6, 32'hD); tick();
        chk("rf_d_out", out_wdata, 64'hD);
        in_valid = 1'b0; tick();
        chk("rf_skid_cleared", out_valid, 0);

        // Lanes and HI/LO
        out_ready = 1'b0;
        in_valid = 1'b1; in_wreg = 2'b10; in_wd = {5'd7, 5'd9};
        in_wdata = {32'h55, 32'h66};
        in_whilo = 1'b1; in_hi = 32'h1; in_lo = 32'h2;
        tick();
        in_valid = 1'b0;
        chk("ln_wreg", out_wreg, 2'b10);
        chk("ln_wd", out_wd, {5'd7, 5'd0});
        chk("ln_wdata", out_wdata, {32'h55, 32'h66});
        chk("ln_whilo", out_whilo, 1);
        chk("ln_hi", out_hi, 32'h1);
        chk("ln_lo", out_lo, 32'h2);
        out_ready = 1'b1; tick();
        chk("ln_bubble_whilo", out_whilo, 0);
        chk("ln_bubble_hi_hold", out_hi, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline boundary register, the successor to the fixed single-port MEM/WB latch.
- Carries NUM_PORTS independent register-write lanes plus a HI/LO write lane from the memory stage to write-back.
- Adds a valid/ready handshake with a two-entry skid buffer, a flush input, and bubble insertion, so write-back can stall without combinational ready paths back into MEM.

Parameters:
- DW, 32, register data width per lane
- AW, 5, register address width per lane
- NUM_PORTS, 1, number of GPR write lanes (1..4)
- NOP_ADDR, 0, address driven on a lane when it has no write

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all buffered entries; drop the current input
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept; driven only by a register
- in_wd  in  NUM_PORTS*AW  destination addresses, lane i at bits [i*AW +: AW]
- in_wreg  in  NUM_PORTS  per-lane write enable
- in_wdata  in  NUM_PORTS*DW  per-lane write data
- in_whilo  in  1  HI/LO write enable
- in_hi, in_lo  in  DW each  HI/LO data
- out_valid  out  1  entry presented to WB
- out_ready  in  1  WB accepts the entry
- out_wd  out  NUM_PORTS*AW  registered addresses
- out_wreg  out  NUM_PORTS  registered write enables, qualified by out_valid
- out_wdata  out  NUM_PORTS*DW  registered data
- out_whilo  out  1  registered HI/LO enable, qualified by out_valid
- out_hi, out_lo  out  DW each  registered HI/LO data

Behaviour:
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives out_*) and skid entry. Each holds the full payload plus a valid bit.
- State is derived from the valid bits:
  - EMPTY: main=0, skid=0
  - ONE: main=1, skid=0
  - FULL: main=1, skid=1
- Transitions, evaluated on each clk edge when rst=0 and flush=0:
  - EMPTY: in_fire -> main<=in, go ONE. Otherwise stay EMPTY.
  - ONE: in_fire & out_fire -> main<=in, stay ONE. in_fire only -> skid<=in, go FULL. out_fire only -> go EMPTY. Neither -> hold.
  - FULL: in_ready=0. out_fire -> main<=skid, go ONE. Otherwise hold.
- in_ready is registered: 1 exactly when the next state is not FULL. It is never a function of out_ready in the same cycle.
- out_valid = main valid bit (registered).
- Latency: an input accepted in EMPTY, or in ONE with a simultaneous out_fire, appears on out_* at the next edge (1 cycle). In steady streaming with out_ready=1, throughput is 1 per cycle.
- Order: strictly FIFO. The skid entry is never presented before the main entry.
- Bubble rule: when out_valid=0, out_wreg and out_whilo are forced to 0. out_wd, out_wdata, out_hi and out_lo hold their last values. A WB stage without handshake therefore never writes a bubble.
- Lane rule: on load, a lane with in_wreg[i]=0 stores NOP_ADDR in its address field. Its data is stored as given. Lanes never interact.
- Flush (priority below rst, above everything else): next state EMPTY, in_ready<=1, and the input presented in the flush cycle is dropped even if in_valid=1. Payload registers need not clear.
- Reset: at a clk edge with rst=1, the following take effect:
  - out_valid=0, in_ready=1
  - out_wreg=0, out_whilo=0
  - out_wd=all lanes NOP_ADDR
  - out_wdata=0, out_hi=0, out_lo=0
  - skid cleared
- Reset mid-operation (including in FULL) discards both entries with no partial output.
- out_ready=1 while out_valid=0 has no effect.
- in_valid while in_ready=0 is ignored; MEM must hold its payload.

Test Plan:
- Reset: assert rst 2 cycles from FULL. Required: out_valid=0, in_ready=1, out_wreg=0, out_wd=0, out_wdata=0 on the cycle after the first reset edge.
- Streaming: out_ready=1; drive in_valid=1 with wd=3/wdata=0x11, wd=4/0x22, wd=5/0x33 on consecutive cycles. Required: the same triples appear on out_* on cycles +1, +2, +3 with out_wreg=1, then out_valid=0 and out_wreg=0.
- Backpressure: out_ready=0; send A(0xA) then B(0xB). Required: after B is accepted, in_ready=0 and out shows A. Raise out_ready: A is consumed, then B shows next cycle, and in_ready=1 again.
- Flush in FULL: with A and B buffered, pulse flush with in_valid=1 carrying C(0xC). Required: next cycle out_valid=0, in_ready=1, and C never appears.
- Lanes: NUM_PORTS=2. Input wreg=2'b10, wd={7,9}, wdata={0x55,0x66}. Required: out_wreg=2'b10, lane0 address=NOP_ADDR, lane1 address=7 with data 0x55. Separately, in_whilo=1 with hi=0x1, lo=0x2 -> out_whilo=1, out_hi=0x1, out_lo=0x2.
